// File: rtl/tdc_fine_encode_ctrl_pkg.sv
// Shared types and constants for the TDC fine-code encode sequencer.
package tdc_enc_pkg;

  localparam int unsigned THERM_W_DEF  = 21;
  localparam int unsigned BIN_W_DEF    = 6;
  localparam int unsigned ERRCNT_W_DEF = 8;

  localparam logic [1:0] LEVEL_MIN = 2'd1;
  localparam logic [1:0] LEVEL_MAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ENC_TOA,
    ENC_TOT,
    OUT
  } state_t;

  // Level 0 is not a usable tolerance; clamp up to the minimum.
  function automatic logic [1:0] start_level(input logic [1:0] cfg);
    return (cfg < LEVEL_MIN) ? LEVEL_MIN : cfg;
  endfunction

endpackage

// File: rtl/tdc_fine_encode_ctrl_if.sv
// Hit-in / result-out handshake bundle between capture stage, sequencer and formatter.
interface tdc_fine_encode_ctrl_if
  import tdc_enc_pkg::*;
#(
  parameter int unsigned THERM_W = THERM_W_DEF,
  parameter int unsigned BIN_W   = BIN_W_DEF
);
  logic               in_valid;
  logic               in_ready;
  logic [THERM_W-1:0] toa_raw;
  logic [THERM_W-1:0] tot_raw;
  logic               out_valid;
  logic               out_ready;
  logic [BIN_W-1:0]   toa_fine;
  logic [BIN_W-1:0]   tot_fine;
  logic               toa_err;
  logic               tot_err;
  logic [1:0]         toa_level;
  logic [1:0]         tot_level;

  modport master (
    output in_valid, toa_raw, tot_raw, out_ready,
    input  in_ready, out_valid, toa_fine, tot_fine, toa_err, tot_err, toa_level, tot_level
  );

  modport slave (
    input  in_valid, toa_raw, tot_raw, out_ready,
    output in_ready, out_valid, toa_fine, tot_fine, toa_err, tot_err, toa_level, tot_level
  );
endinterface

// File: rtl/tdc_fine_encode_ctrl_enc.sv
// Combinational thermometer-to-binary encoder with level-dependent bubble tolerance.
module fine_therm_encoder
  import tdc_enc_pkg::*;
#(
  parameter int unsigned THERM_W = THERM_W_DEF,
  parameter int unsigned BIN_W   = BIN_W_DEF
) (
  input  logic [THERM_W-1:0] encode_In,
  input  logic [1:0]         level,
  output logic [BIN_W-1:0]   Binary_Out,
  output logic               bubbleError
);

  logic [THERM_W-1:0] above;
  logic [THERM_W-1:0] z1;
  logic [THERM_W-1:0] z2;
  logic [THERM_W-1:0] z3;

  // Output is the position of the topmost one; above[i] marks bits lying under it.
  always_comb begin
    above      = '0;
    Binary_Out = '0;
    for (int unsigned i = 0; i < THERM_W; i++) begin
      above[i] = |(encode_In >> (i + 1));
      if (encode_In[i]) Binary_Out = BIN_W'(i + 1);
    end
  end

  // zN[i]: a run of at least N bubble zeros starts at bit i.
  assign z1 = ~encode_In & above;
  assign z2 = z1 & (z1 >> 1);
  assign z3 = z2 & (z1 >> 2);

  // A level tolerates bubble runs shorter than the level.
  always_comb begin
    case (level)
      2'd2:    bubbleError = |z2;
      2'd3:    bubbleError = |z3;
      default: bubbleError = |z1;
    endcase
  end

endmodule

// File: rtl/tdc_fine_encode_ctrl.sv
// Shares one fine encoder between the TOA and TOT codes of a hit, escalating
// bubble tolerance on errors within a retry budget, and returns both fine codes.
module tdc_fine_encode_ctrl
  import tdc_enc_pkg::*;
#(
  parameter int unsigned THERM_W  = THERM_W_DEF,
  parameter int unsigned BIN_W    = BIN_W_DEF,
  parameter int unsigned ERRCNT_W = ERRCNT_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [1:0]          cfg_level,
  input  logic [1:0]          cfg_max_retry,
  input  logic                err_cnt_clr,
  tdc_fine_encode_ctrl_if.slave bus,
  output logic [ERRCNT_W-1:0] err_cnt
);

  state_t             state_q, state_d;
  logic [1:0]         level_q, level_d;
  logic [1:0]         retry_q, retry_d;
  logic [THERM_W-1:0] toa_q, tot_q;
  logic [THERM_W-1:0] enc_in;
  logic [BIN_W-1:0]   enc_bin;
  logic               enc_bub;
  logic               accept, commit_toa, commit_tot, leave;

  fine_therm_encoder #(
    .THERM_W (THERM_W),
    .BIN_W   (BIN_W)
  ) u_enc (
    .encode_In   (enc_in),
    .level       (level_q),
    .Binary_Out  (enc_bin),
    .bubbleError (enc_bub)
  );

  assign enc_in        = (state_q == ENC_TOT) ? tot_q : toa_q;
  assign bus.in_ready  = rstn && en && (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    retry_d    = retry_q;
    accept     = 1'b0;
    commit_toa = 1'b0;
    commit_tot = 1'b0;
    leave      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          accept  = 1'b1;
          level_d = start_level(cfg_level);
          retry_d = '0;
          state_d = ENC_TOA;
        end
      end
      ENC_TOA, ENC_TOT: begin
        if (enc_bub && (level_q < LEVEL_MAX) && (retry_q < cfg_max_retry)) begin
          level_d = level_q + 2'd1;
          retry_d = retry_q + 2'd1;
        end else begin
          level_d = start_level(cfg_level);
          retry_d = '0;
          if (state_q == ENC_TOA) begin
            commit_toa = 1'b1;
            state_d    = ENC_TOT;
          end else begin
            commit_tot = 1'b1;
            state_d    = OUT;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          leave   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      level_q <= LEVEL_MIN;
      retry_q <= '0;
      toa_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      retry_q <= retry_d;
      if (accept) begin
        toa_q <= bus.toa_raw;
        tot_q <= bus.tot_raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.toa_fine  <= '0;
      bus.tot_fine  <= '0;
      bus.toa_err   <= 1'b0;
      bus.tot_err   <= 1'b0;
      bus.toa_level <= '0;
      bus.tot_level <= '0;
    end else begin
      if (commit_toa) begin
        bus.toa_fine  <= enc_bin;
        bus.toa_err   <= enc_bub;
        bus.toa_level <= level_q;
      end
      if (commit_tot) begin
        bus.tot_fine  <= enc_bin;
        bus.tot_err   <= enc_bub;
        bus.tot_level <= level_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (leave && (bus.toa_err || bus.tot_err) && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule
